// File: rtl/cpu_ifetch_queue.sv
// cpu_ifetch_queue: instruction fetch unit with a multi-line prefetch queue.
// Requests whole cache lines ahead of decode and buffers up to LINE_BUFS lines.
// It presents one instruction per cycle through a valid/ready handshake.
// A redirect flushes the queue and discards any in-flight stale line.
//
// Ports:
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_redirect, i_redirect_pc  load a new fetch PC (highest priority)
//   o_valid, i_ready           decode handshake
//   o_pc, o_instruction        presented instruction and its PC
//   o_cache_valid, o_cache_addr, i_cache_ready   line read request
//   i_cache_rvalid, i_cache_rdata                line read response
module cpu_ifetch_queue #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINE_BUFS  = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_redirect,
  input  logic [31:0]               i_redirect_pc,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [31:0]               o_pc,
  output logic [31:0]               o_instruction,
  output logic                      o_cache_valid,
  output logic [31:0]               o_cache_addr,
  input  logic                      i_cache_ready,
  input  logic                      i_cache_rvalid,
  input  logic [32*LINE_WORDS-1:0]  i_cache_rdata
);

  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
  localparam int unsigned LSB_W      = OFF_W + 2;
  localparam int unsigned PTR_W      = (LINE_BUFS > 1) ? $clog2(LINE_BUFS) : 1;
  localparam int unsigned CNT_W      = $clog2(LINE_BUFS + 1);
  localparam logic [31:0] LINE_BYTES = 32'(4 * LINE_WORDS);
  localparam logic [31:0] BASE_MASK  = ~(LINE_BYTES - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [31:0]             r_fp;
  logic [31:0]             r_req_base;
  logic [31:0]             r_pend_pc;
  logic [OFF_W-1:0]        r_off;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;
  logic [31:0]             r_base [LINE_BUFS];
  logic [32*LINE_WORDS-1:0] r_data [LINE_BUFS];

  logic                    w_full;
  logic                    w_accept;
  logic                    w_consume;
  logic                    w_pop;
  logic                    w_push;
  logic [32*LINE_WORDS-1:0] w_head_line;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LINE_BUFS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request only with a free slot so every response has room to land.
  assign w_full        = (r_count == CNT_W'(LINE_BUFS));
  assign o_cache_valid = (r_state == S_IDLE) && !w_full && !i_reset;
  assign o_cache_addr  = r_fp;
  assign w_accept      = o_cache_valid && i_cache_ready;

  // Presentation from registered state only.
  assign w_head_line   = r_data[r_head];
  assign o_valid       = (r_count != '0);
  assign o_instruction = o_valid ? w_head_line[{r_off, 5'b0} +: 32] : 32'd0;
  assign o_pc          = o_valid ? (r_base[r_head] | 32'({r_off, 2'b00})) : r_pend_pc;

  assign w_consume = o_valid && i_ready && !i_redirect;
  assign w_pop     = w_consume && (r_off == OFF_W'(LINE_WORDS - 1));
  assign w_push    = (r_state == S_WAIT) && i_cache_rvalid && !i_redirect;

  // Request FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request FSM next state; a redirect turns any accepted request stale.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_redirect)    w_state_nxt = w_accept ? S_DROP : S_IDLE;
        else if (w_accept) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_cache_rvalid)  w_state_nxt = S_IDLE;
        else if (i_redirect) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (i_cache_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch pointer, queue pointers, occupancy and head word offset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fp       <= RESET_PC & BASE_MASK;
      r_req_base <= 32'd0;
      r_pend_pc  <= {RESET_PC[31:2], 2'b00};
      r_off      <= RESET_PC[LSB_W-1:2];
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      // Start offset is held in r_off: the queue is empty, so the first
      // pushed line becomes head and nothing consumes before it arrives.
      r_fp      <= i_redirect_pc & BASE_MASK;
      r_pend_pc <= {i_redirect_pc[31:2], 2'b00};
      r_off     <= i_redirect_pc[LSB_W-1:2];
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      if (w_accept) begin
        r_fp       <= r_fp + LINE_BYTES;
        r_req_base <= r_fp;
      end
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_consume) r_off <= w_pop ? '0 : r_off + OFF_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Line storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_base[r_tail] <= r_req_base;
      r_data[r_tail] <= i_cache_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_ifetch_queue.sv
// Testbench for cpu_ifetch_queue: 1-cycle cache model, table-driven start-up
// vectors, then hand-written redirect, stall, wrap and reset sequences.
module tb_cpu_ifetch_queue;

  logic         clk;
  logic         rst;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         ready;
  logic         cache_ready;
  logic         cache_rvalid;
  logic [127:0] cache_rdata;
  logic         o_valid;
  logic [31:0]  o_pc;
  logic [31:0]  o_instruction;
  logic         o_cache_valid;
  logic [31:0]  o_cache_addr;

  cpu_ifetch_queue #(
    .LINE_WORDS (4),
    .LINE_BUFS  (2),
    .RESET_PC   (32'h0000_0100)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_valid        (o_valid),
    .i_ready        (ready),
    .o_pc           (o_pc),
    .o_instruction  (o_instruction),
    .o_cache_valid  (o_cache_valid),
    .o_cache_addr   (o_cache_addr),
    .i_cache_ready  (cache_ready),
    .i_cache_rvalid (cache_rvalid),
    .i_cache_rdata  (cache_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Values captured mid-cycle, just before the rising edge.
  logic        s_valid, s_cv, s_rdy, s_acc;
  logic [31:0] s_pc, s_ins, s_addr;
  logic        manual = 1'b0;

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_cv;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = ins_of(base + 32'(4 * k));
    return d;
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                              input logic cv, input logic [31:0] a);
    vec_t t;
    t.ready = r; t.exp_valid = v; t.exp_pc = pc; t.exp_cv = cv; t.exp_addr = a;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Capture the current cycle, cross the edge, then run the cache model.
  task automatic tick();
    @(negedge clk);
    s_valid = o_valid;
    s_pc    = o_pc;
    s_ins   = o_instruction;
    s_cv    = o_cache_valid;
    s_addr  = o_cache_addr;
    s_rdy   = ready;
    s_acc   = o_cache_valid && cache_ready;
    @(posedge clk);
    #1;
    cache_rvalid = s_acc && !manual;
    cache_rdata  = line_of(s_addr);
  endtask

  // Run until the next handshake and compare the consumed PC/instruction.
  task automatic expect_pc(input string name, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick();
      if (s_valid && s_rdy) ok = 1'b1;
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_pc"}, s_pc, exp);
      chk({name, "_ins"}, s_ins, ins_of(exp));
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    int  acc_cnt;
    bit  seen;

    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; ready = 1'b1;
    cache_ready = 1'b1; cache_rvalid = 1'b0; cache_rdata = '0;

    tbl[0] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h100);
    tbl[1] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    tbl[2] = mk(1'b1, 1'b1, 32'h100, 1'b1, 32'h110);
    tbl[3] = mk(1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    tbl[4] = mk(1'b1, 1'b1, 32'h108, 1'b0, 32'h0);
    tbl[5] = mk(1'b1, 1'b1, 32'h10C, 1'b0, 32'h0);
    tbl[6] = mk(1'b1, 1'b1, 32'h110, 1'b1, 32'h120);
    tbl[7] = mk(1'b1, 1'b1, 32'h114, 1'b0, 32'h0);
    tbl[8] = mk(1'b1, 1'b1, 32'h118, 1'b0, 32'h0);
    tbl[9] = mk(1'b1, 1'b1, 32'h11C, 1'b0, 32'h0);

    // Reset values
    tick();
    tick();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_ins",   s_ins, 32'd0);
    chk("rst_pc",    s_pc, 32'h100);
    chk("rst_cv",    32'(s_cv), 32'd0);
    rst = 1'b0;

    // Start-up stream: no bubbles after the first instruction
    for (int i = 0; i < 10; i++) begin
      ready = tbl[i].ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_cv", i), 32'(s_cv), 32'(tbl[i].exp_cv));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d_ins", i), s_ins, ins_of(tbl[i].exp_pc));
      end else begin
        chk($sformatf("vec%0d_ins0", i), s_ins, 32'd0);
      end
      if (tbl[i].exp_cv) chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].exp_addr);
    end

    // Redirect while waiting for 0x130: stale line dropped
    manual = 1'b1;
    tick();
    chk("drop_req_cv", 32'(s_cv), 32'd1);
    chk("drop_req_addr", s_addr, 32'h130);
    chk("drop_req_pc", s_pc, 32'h120);
    do_redirect(32'h0000_020C);
    chk("drop_redir_pc", s_pc, 32'h124);
    tick();
    chk("drop_valid", 32'(s_valid), 32'd0);
    chk("drop_cv", 32'(s_cv), 32'd0);
    cache_rvalid = 1'b1;
    cache_rdata  = line_of(32'h130);
    tick();
    chk("drop_rv_cv", 32'(s_cv), 32'd0);
    manual = 1'b0;
    tick();
    chk("drop_after_valid", 32'(s_valid), 32'd0);
    chk("drop_after_cv", 32'(s_cv), 32'd1);
    chk("drop_after_addr", s_addr, 32'h200);
    expect_pc("drop_first", 32'h20C);
    expect_pc("drop_second", 32'h210);

    // Decode stalled for 20 cycles: exactly two lines fetched
    ready = 1'b0;
    do_redirect(32'h0000_0400);
    acc_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (s_acc) acc_cnt++;
    end
    chk("stall_requests", 32'(acc_cnt), 32'd2);
    chk("stall_cv", 32'(s_cv), 32'd0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_pc", s_pc, 32'h400);
    ready = 1'b1;
    for (int i = 0; i < 9; i++)
      expect_pc($sformatf("stall_seq%0d", i), 32'h400 + 32'(4 * i));

    // Fetch pointer wrap at the top of the address space
    do_redirect(32'hFFFF_FFF8);
    expect_pc("wrap0", 32'hFFFF_FFF8);
    expect_pc("wrap1", 32'hFFFF_FFFC);
    expect_pc("wrap2", 32'h0000_0000);
    expect_pc("wrap3", 32'h0000_0004);

    // Redirect coincident with a response and i_ready=1
    ready = 1'b0;
    do_redirect(32'h0000_0300);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (s_valid) seen = 1'b1;
    end
    chk("coin_fill_timeout", 32'(seen), 32'd1);
    ready = 1'b1;
    do_redirect(32'h0000_0500);
    chk("coin_valid", 32'(s_valid), 32'd1);
    chk("coin_pc", s_pc, 32'h300);
    tick();
    chk("coin_after_valid", 32'(s_valid), 32'd0);
    chk("coin_after_cv", 32'(s_cv), 32'd1);
    chk("coin_after_addr", s_addr, 32'h500);
    expect_pc("coin_first", 32'h500);

    // Reset during S_WAIT, stale response afterwards
    manual = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (s_acc) seen = 1'b1;
    end
    chk("mrst_req_timeout", 32'(seen), 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(s_valid), 32'd0);
    chk("mrst_ins", s_ins, 32'd0);
    chk("mrst_pc", s_pc, 32'h100);
    chk("mrst_cv", 32'(s_cv), 32'd0);
    rst = 1'b0;
    cache_ready  = 1'b0;
    cache_rvalid = 1'b1;
    cache_rdata  = ~line_of(32'h100);
    tick();
    chk("mrst_stale_cv", 32'(s_cv), 32'd1);
    chk("mrst_stale_addr", s_addr, 32'h100);
    cache_ready = 1'b1;
    manual = 1'b0;
    tick();
    chk("mrst_nopush_valid", 32'(s_valid), 32'd0);
    chk("mrst_fresh_addr", s_addr, 32'h100);
    expect_pc("mrst_first", 32'h100);
    expect_pc("mrst_second", 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_ifetch_queue.md
# cpu_ifetch_queue

Parametrised instruction fetch unit with a multi-line prefetch queue. It requests whole cache lines of LINE_WORDS instructions from the instruction cache ahead of the pipeline and buffers up to LINE_BUFS lines. It presents one instruction per cycle to decode via a valid/ready handshake. Redirects (branches, traps) flush the queue and discard any in-flight stale cache response. It sits between the pipeline front end and the cache_interface-style instruction cache.

## Interface
- LINE_WORDS, 4, 32-bit instructions per cache line; power of two, 2..16
- LINE_BUFS, 2, line entries in prefetch queue; 1..8
- RESET_PC, rapid_pkg::RESET_VECTOR, first fetch address after reset; low 2 bits must be 0
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_redirect  in  1  load new fetch PC; has priority over every other event that cycle
- i_redirect_pc  in  32  target PC; bits [1:0] ignored (treated as 0)
- o_valid  out  1  o_pc/o_instruction valid
- i_ready  in  1  decode accepts instruction this cycle
- o_pc  out  32  PC of presented instruction
- o_instruction  out  32  presented instruction; 0 when o_valid=0
- o_cache_valid  out  1  line read request
- o_cache_addr  out  32  line-aligned request address (low log2(LINE_WORDS)+2 bits 0)
- i_cache_ready  in  1  cache accepts request this cycle
- i_cache_rvalid  in  1  response data valid
- i_cache_rdata  in  32*LINE_WORDS  line data; word k at [32k +: 32]

## Operation
- Queue: circular buffer of LINE_BUFS entries {line base, data}; head/tail pointers plus occupancy count 0..LINE_BUFS.
- Head word offset (log2(LINE_WORDS) bits) selects the instruction; o_pc = head base + 4*offset.
- Fetch pointer fp: next line base to request; advances by 4*LINE_WORDS on each accepted request, mod 2^32 (0xFFFF_FFF0 -> 0x0 for LINE_WORDS=4).
- At most one outstanding request. Request FSM:
  - S_IDLE: o_cache_valid=1 when occupancy < LINE_BUFS; on i_cache_ready -> S_WAIT, fp advances.
  - S_WAIT: on i_cache_rvalid push {request base, rdata} at tail -> S_IDLE. On i_redirect (no rvalid same cycle) -> S_DROP. Redirect with rvalid same cycle: data discarded -> S_IDLE.
  - S_DROP: o_cache_valid=0; on i_cache_rvalid discard data -> S_IDLE. A further redirect stays in S_DROP.
- Occupancy reserve: in S_IDLE a request is issued only if a slot is free, so a response always has room.
- Consume: o_valid = occupancy>0. On o_valid && i_ready && !i_redirect the offset increments. At offset LINE_WORDS-1 the head pops and the next entry starts at offset 0.
- Redirect: queue emptied; fp = line base of i_redirect_pc; first-line start offset = i_redirect_pc word index (latched, applied when that line reaches head). Handshake in the redirect cycle is void.
- Push and pop in the same cycle are legal; occupancy unchanged.
- i_cache_rvalid in S_IDLE (protocol error) is ignored.

## Timing
- Reset values: o_valid=0, o_instruction=0, o_pc=RESET_PC, o_cache_valid=0; state S_IDLE, occupancy 0, fp=line base of RESET_PC, start offset=RESET_PC word index.
- First request is asserted in the first cycle after reset deasserts.
- o_cache_valid, o_cache_addr, o_valid, o_pc and o_instruction derive from registered state only; no combinational path from i_ready or i_redirect.
- With a 1-cycle cache (rvalid the cycle after acceptance), redirect at cycle N from S_IDLE: request at N+1, rvalid at N+2, o_valid at N+3.
- Sustained throughput is 1 instr/cycle when LINE_WORDS ≥ 2·(cache latency+1) and LINE_BUFS ≥ 2.
- Reset asserted mid-request: all state cleared immediately; a later rvalid for the aborted request is ignored (S_IDLE).

## Test plan
- Reset with RESET_PC=0x100, 1-cycle cache, i_ready=1 -> requests 0x100,0x110,…; o_pc 0x100,0x104,0x108,… one per cycle with no bubbles after the first.
- Redirect to 0x20C while S_WAIT for 0x130 -> 0x130 data dropped (S_DROP), next request 0x200, first o_pc=0x20C, then 0x210.
- i_ready=0 for 20 cycles, LINE_BUFS=2 -> exactly 2 lines buffered, o_cache_valid=0 while full; resumed output is in order with no lost or duplicate PC.
- fp at 0xFFFF_FFF0 -> next request 0x0000_0000; o_pc sequence 0xFFFF_FFFC, 0x0.
- Redirect coincident with i_cache_rvalid and i_ready=1 -> response discarded, no instruction consumed, next request is the redirect line.
- Reset asserted while S_WAIT, then cache rvalid one cycle later -> outputs at reset values, no push, fresh request to the RESET_PC line.
